// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV, DIVU, REM, REMU).
// Performs one restoring-division step per clock. Results go straight to the
// register-file write port as a (wb_data, wb_rd, wb_en) triple. Divide-by-zero
// and signed overflow finish without iterating.
module div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] wb_data,
    output logic [4:0]      wb_rd,
    output logic            wb_en
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Two's-complement negate when requested; also used for sign correction.
    function automatic logic [XLEN-1:0] applySign(input logic [XLEN-1:0] val, input logic neg);
        return neg ? (~val + XLEN'(1)) : val;
    endfunction

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic [XLEN-1:0]  quoReg;     // dividend bits shift out MSB first, quotient bits shift in
    logic [XLEN-1:0]  remReg;
    logic [XLEN-1:0]  divReg;     // divisor magnitude
    logic             negQ;
    logic             negR;
    logic             selRem;
    logic [4:0]       rdReg;

    logic                    isSigned;
    logic signed [XLEN-1:0]  dividendS;
    logic signed [XLEN-1:0]  divisorS;
    logic                    aNeg;
    logic                    bNeg;
    logic [XLEN-1:0]         aMag;
    logic [XLEN-1:0]         bMag;
    logic                    divZero;
    logic                    overflow;

    logic [XLEN:0]   remShift;
    logic [XLEN-1:0] remDiff;
    logic            geq;
    logic [XLEN-1:0] remNext;
    logic [XLEN-1:0] quoNext;

    // Operand decode for the start cycle: sign flags, magnitudes, special cases.
    always_comb begin
        isSigned  = ~op[0];
        dividendS = signed'(rs1_data);
        divisorS  = signed'(rs2_data);
        aNeg      = isSigned & (dividendS < 0);
        bNeg      = isSigned & (divisorS < 0);
        aMag      = applySign(rs1_data, aNeg);
        bMag      = applySign(rs2_data, bNeg);
        divZero   = (rs2_data == '0);
        overflow  = isSigned && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // When the subtraction succeeds the true difference is below the divisor,
    // so the low XLEN bits of the difference are exact.
    always_comb begin
        remShift = {remReg, quoReg[XLEN-1]};
        geq      = (remShift >= {1'b0, divReg});
        remDiff  = remShift[XLEN-1:0] - divReg;
        remNext  = geq ? remDiff : remShift[XLEN-1:0];
        quoNext  = {quoReg[XLEN-2:0], geq};
    end

    // Control FSM, iteration datapath and registered write-back outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            count   <= '0;
            quoReg  <= '0;
            remReg  <= '0;
            divReg  <= '0;
            negQ    <= 1'b0;
            negR    <= 1'b0;
            selRem  <= 1'b0;
            rdReg   <= '0;
            wb_data <= '0;
            wb_rd   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !flush) begin
                        selRem <= op[1];
                        rdReg  <= rd;
                        negQ   <= aNeg ^ bNeg;
                        negR   <= aNeg;
                        count  <= '0;
                        if (divZero) begin
                            state   <= ST_DONE;
                            quoReg  <= '1;
                            remReg  <= rs1_data;
                            wb_data <= op[1] ? rs1_data : '1;
                            wb_rd   <= rd;
                        end else if (overflow) begin
                            state   <= ST_DONE;
                            quoReg  <= rs1_data;
                            remReg  <= '0;
                            wb_data <= op[1] ? '0 : rs1_data;
                            wb_rd   <= rd;
                        end else begin
                            state  <= ST_CALC;
                            quoReg <= aMag;
                            remReg <= '0;
                            divReg <= bMag;
                        end
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else begin
                        quoReg <= quoNext;
                        remReg <= remNext;
                        count  <= count + CNT_W'(1);
                        if (count == CNT_W'(XLEN - 1)) begin
                            state   <= ST_DONE;
                            wb_data <= selRem ? applySign(remNext, negR) : applySign(quoNext, negQ);
                            wb_rd   <= rdReg;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Status and write enable; a flush in DONE suppresses the completion.
    always_comb begin
        busy  = (state != ST_IDLE);
        done  = (state == ST_DONE) && !flush;
        wb_en = done && (wb_rd != 5'd0);
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard testbench for div_unit: directed vectors push expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [4:0]  rd = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_en;

    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        en;
        int          startCyc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   passCnt = 0;
    int   totalCnt = 0;
    int   cyc = 0;
    int   doneCnt = 0;
    int   pushCnt = 0;

    div_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rd(rd), .flush(flush),
        .busy(busy), .done(done), .wb_data(wb_data), .wb_rd(wb_rd), .wb_en(wb_en)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            doneCnt++;
            if (sb.size() == 0) begin
                check("spurious_done", {31'b0, done}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wb_data", wb_data, e.data);
                check("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
                check("wb_en", {31'b0, wb_en}, {31'b0, e.en});
                check("latency", 32'(cyc - e.startCyc), 32'(e.lat));
            end
        end
    end

    // Issue one request; operands are scrambled right after the start edge.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r, input logic [31:0] expData, input int lat,
                          input bit expect_done);
        exp_t e;
        @(negedge clk);
        start = 1'b1; op = o; rs1_data = a; rs2_data = b; rd = r;
        @(posedge clk);
        #1;
        if (expect_done) begin
            e.data = expData; e.rd = r; e.en = (r != 5'd0);
            e.startCyc = cyc; e.lat = lat;
            sb.push_back(e);
            pushCnt++;
        end
        start = 1'b0;
        rs1_data = $urandom; rs2_data = $urandom; rd = 5'($urandom); op = 2'($urandom);
    endtask

    // Count negedge samples with busy high until the unit is idle again.
    task automatic waitIdle(output int n);
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) check("busy_timeout", 32'(n), 32'd0);
    endtask

    task automatic runOp(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] r, input logic [31:0] expData,
                         input bit special);
        int n;
        launch(o, a, b, r, expData, special ? 0 : 32, 1'b1);
        waitIdle(n);
        check({name, "_busy_cycles"}, 32'(n), special ? 32'd1 : 32'd33);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_wb_en", {31'b0, wb_en}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_rd", {27'b0, wb_rd}, 32'd0);
        rst = 1'b0;

        // Signed, unsigned and sign-mix normal cases
        runOp("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFD, 1'b0);
        runOp("rem_m7_2", OP_REM, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFF, 1'b0);
        runOp("divu_max_16", OP_DIVU, 32'hFFFFFFFF, 32'd16, 5'd7, 32'h0FFFFFFF, 1'b0);
        runOp("remu_max_16", OP_REMU, 32'hFFFFFFFF, 32'd16, 5'd8, 32'h0000000F, 1'b0);
        runOp("div_7_m2", OP_DIV, 32'd7, 32'hFFFFFFFE, 5'd10, 32'hFFFFFFFD, 1'b0);
        runOp("rem_7_m2", OP_REM, 32'd7, 32'hFFFFFFFE, 5'd11, 32'd1, 1'b0);
        runOp("divu_min_m1", OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0, 1'b0);

        // Special cases finish in one cycle
        runOp("div_by_zero", OP_DIV, 32'd1234, 32'd0, 5'd13, 32'hFFFFFFFF, 1'b1);
        runOp("rem_by_zero", OP_REM, 32'd1234, 32'd0, 5'd14, 32'd1234, 1'b1);
        runOp("remu_by_zero", OP_REMU, 32'h80000000, 32'd0, 5'd15, 32'h80000000, 1'b1);
        runOp("div_overflow", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000, 1'b1);
        runOp("rem_overflow", OP_REM, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'd0, 1'b1);

        // rd=0 with a second start ignored mid-operation
        launch(OP_DIVU, 32'd100, 32'd7, 5'd0, 32'd14, 32, 1'b1);
        repeat (9) @(negedge clk);
        start = 1'b1; op = OP_DIVU; rs1_data = 32'd50; rs2_data = 32'd5; rd = 5'd3;
        @(negedge clk);
        start = 1'b0;
        waitIdle(n);
        repeat (40) @(negedge clk);
        check("ignored_start_busy", {31'b0, busy}, 32'd0);

        // Reset mid-operation aborts without completion
        launch(OP_DIVU, 32'd100, 32'd7, 5'd4, 32'd0, 0, 1'b0);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_wb_en", {31'b0, wb_en}, 32'd0);
        check("midrst_wb_data", wb_data, 32'd0);
        check("midrst_wb_rd", {27'b0, wb_rd}, 32'd0);
        repeat (40) @(negedge clk);
        runOp("divu_9_3", OP_DIVU, 32'd9, 32'd3, 5'd9, 32'd3, 1'b0);

        // Flush in CALC, then back-to-back start
        launch(OP_DIV, 32'd1000, 32'd3, 5'd6, 32'd0, 0, 1'b0);
        repeat (19) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'd0);
        runOp("div_after_flush", OP_DIV, 32'hFFFFFF9C, 32'd10, 5'd18, 32'hFFFFFFF6, 1'b0);

        // Flush beats start in IDLE
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = OP_DIVU; rs1_data = 32'd8; rs2_data = 32'd2; rd = 5'd19;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_over_start_busy", {31'b0, busy}, 32'd0);

        // Output hold after completion
        repeat (5) @(negedge clk);
        check("hold_wb_data", wb_data, 32'hFFFFFFF6);
        check("hold_wb_rd", {27'b0, wb_rd}, 32'd18);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        check("done_count", 32'(doneCnt), 32'(pushCnt));
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
